// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-masked doubleword RAM plus a 32-byte MMIO page
// (CYCLE, TOHOST, CONSOLE, STATUS). Define DMEM_CONSOLE_EN to build the console FIFO.
module dmem_responder #(
    parameter int          DEPTH      = 512,
    parameter int          ADDR_WIDE  = 29,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] addr,
    input  logic        wr_en,
    input  logic [63:0] wdata,
    input  logic [7:0]  wmask,
    output logic [63:0] rdata,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        REG_CYCLE   = 2'd0,
        REG_TOHOST  = 2'd1,
        REG_CONSOLE = 2'd2,
        REG_STATUS  = 2'd3
    } mmio_reg_e;

    logic [ADDR_WIDE-1:0] word_idx;
    logic [RAM_AW-1:0]    ram_idx;
    logic                 is_mmio;
    logic                 ram_hit;
    mmio_reg_e            mmio_sel;
    logic [63:0]          bmask;
    logic                 mmio_wr;

    assign word_idx = addr[3 +: ADDR_WIDE];
    assign ram_idx  = word_idx[RAM_AW-1:0];
    assign is_mmio  = (addr[31:5] == MMIO_BASE[31:5]);
    assign ram_hit  = !is_mmio && (word_idx < ADDR_WIDE'(DEPTH));
    assign mmio_sel = mmio_reg_e'(addr[4:3]);
    assign mmio_wr  = wr_en && is_mmio;

    always_comb begin
        for (int b = 0; b < 8; b++) begin
            bmask[8*b +: 8] = {8{wmask[b]}};
        end
    end

    // ---------------------------------------------------------------- RAM
    logic [63:0] ram [DEPTH];

    // NOTE: storage arrays have no reset branch so they map onto plain RAM macros;
    // contents are undefined until written.
    always_ff @(posedge clk) begin
        if (wr_en && ram_hit) begin
            ram[ram_idx] <= (ram[ram_idx] & ~bmask) | (wdata & bmask);
        end
    end

    // ------------------------------------------------------- CYCLE / TOHOST
    logic [63:0] cycle;
    logic [63:0] tohost;
    logic [63:0] tohost_next;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        tohost_next = tohost;
        if (mmio_wr && mmio_sel == REG_TOHOST) begin
            tohost_next = (tohost & ~bmask) | (wdata & bmask);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cycle  <= '0;
            tohost <= '0;
            halt   <= 1'b0;
        end else begin
            cycle  <= cycle + 64'd1;
            tohost <= tohost_next;
            halt   <= |tohost_next;
        end
    end

    assign halt_code = tohost[31:0];

    // ------------------------------------------------------------- console
    logic [63:0] status_rd;
    logic        unused_bits;

`ifdef DMEM_CONSOLE_EN
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = FIFO_AW + 1;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic               full;
    logic               push_req;
    logic               do_push;
    logic               pop;
    logic               ovf_set;
    logic               ovf_clr;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign push_req = mmio_wr && mmio_sel == REG_CONSOLE && wmask[0];
    assign pop      = console_valid && console_ready;
    // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_push  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = mmio_wr && mmio_sel == REG_STATUS && wmask[0] && wdata[0];

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign console_valid = (count != '0);
    assign console_data  = fifo_mem[rd_ptr];
    assign status_rd     = {55'd0, 5'(count), 2'b00, full, overflow};
    assign unused_bits   = ^{addr[2:0]};
`else
    assign console_valid = 1'b0;
    assign console_data  = 8'd0;
    assign status_rd     = 64'd0;
    assign unused_bits   = ^{addr[2:0], console_ready};
`endif

    // ---------------------------------------------------------- read path
    always_comb begin
        rdata = '0;
        if (is_mmio) begin
            case (mmio_sel)
                REG_CYCLE:   rdata = cycle;
                REG_TOHOST:  rdata = tohost;
                REG_CONSOLE: rdata = '0;
                REG_STATUS:  rdata = status_rd;
                default:     rdata = '0;
            endcase
        end else if (ram_hit) begin
            rdata = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; console checks follow DMEM_CONSOLE_EN.
module tb_dmem_responder;

    localparam logic [31:0] BASE       = 32'hFFFF_0000;
    localparam int          DEPTH      = 512;
    localparam int          FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] addr;
    logic        wr_en;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata;
    logic        halt;
    logic [31:0] halt_code;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        console_ready;

    int checks = 0;
    int errors = 0;

    dmem_responder #(
        .DEPTH(DEPTH), .ADDR_WIDE(29), .MMIO_BASE(BASE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .nrst(nrst), .addr(addr), .wr_en(wr_en), .wdata(wdata),
        .wmask(wmask), .rdata(rdata), .halt(halt), .halt_code(halt_code),
        .console_valid(console_valid), .console_data(console_data),
        .console_ready(console_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        @(negedge clk);
        addr = a; wdata = d; wmask = m; wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; wmask = 8'h00;
    endtask

    task automatic rd(input logic [31:0] a, output logic [63:0] d);
        addr = a;
        #1;
        d = rdata;
    endtask

    logic [63:0] v;
    logic [63:0] v2;

    initial begin
        nrst = 1'b0; addr = BASE; wr_en = 1'b0; wdata = '0; wmask = '0; console_ready = 1'b0;
        #1;
        check("reset_halt", {63'd0, halt}, 64'd0);
        check("reset_halt_code", {32'd0, halt_code}, 64'd0);
        check("reset_console_valid", {63'd0, console_valid}, 64'd0);
        check("reset_cycle", rdata, 64'd0);

        // Cycle counter: 10 edges after release reads 10, next edge reads 11.
        @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        v = rdata;
        check("cycle_10", v, 64'd10);
        @(posedge clk);
        #1;
        check("cycle_step", rdata - v, 64'd1);

        // RAM masking and same-cycle read-old behaviour.
        wr(32'h40, 64'h1122_3344_5566_7788, 8'hFF);
        rd(32'h40, v);
        check("ram_full_write", v, 64'h1122_3344_5566_7788);
        @(negedge clk);
        addr = 32'h40; wdata = 64'hAAAA; wmask = 8'h03; wr_en = 1'b1;
        #1;
        check("ram_read_old", rdata, 64'h1122_3344_5566_7788);
        @(posedge clk);
        #1;
        wr_en = 1'b0; wmask = 8'h00;
        rd(32'h40, v);
        check("ram_masked", v, 64'h1122_3344_5566_AAAA);
        wr(32'h40, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        rd(32'h40, v);
        check("ram_mask_zero", v, 64'h1122_3344_5566_AAAA);
        wr(32'h48, 64'h0123_4567_89AB_CDEF, 8'hF0);
        rd(32'h48, v);
        check("ram_upper_bytes", v & 64'hFFFF_FFFF_0000_0000, 64'h0123_4567_0000_0000);
        wr(DEPTH * 8, 64'hDEAD_BEEF, 8'hFF);
        rd(DEPTH * 8, v);
        check("ram_out_of_range", v, 64'd0);
        rd(32'h8, v2);
        rd(32'h0, v);

        // Halt register.
        @(negedge clk);
        addr = BASE + 32'h8; wdata = 64'h1; wmask = 8'h0F; wr_en = 1'b1;
        #1;
        check("halt_before_edge", {63'd0, halt}, 64'd0);
        @(posedge clk);
        #1;
        wr_en = 1'b0; wmask = 8'h00;
        check("halt_set", {63'd0, halt}, 64'd1);
        check("halt_code_set", {32'd0, halt_code}, 64'd1);
        rd(BASE + 32'h8, v);
        check("tohost_read", v, 64'd1);
        wr(BASE + 32'h8, 64'd0, 8'hFF);
        check("halt_cleared", {63'd0, halt}, 64'd0);
        wr(BASE + 32'h8, 64'h0000_0001_0000_0000, 8'hF0);
        check("halt_upper_word", {63'd0, halt}, 64'd1);
        check("halt_code_upper", {32'd0, halt_code}, 64'd0);
        wr(BASE, 64'hFFFF, 8'hFF);
        rd(BASE + 32'h8, v);
        check("tohost_unchanged", v, 64'h0000_0001_0000_0000);

        // Asynchronous reset mid-cycle while halted.
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("async_halt", {63'd0, halt}, 64'd0);
        rd(BASE, v);
        check("async_cycle", v, 64'd0);
        rd(32'h40, v);
        check("ram_survives_reset", v, 64'h1122_3344_5566_AAAA);
        @(negedge clk);
        nrst = 1'b1;

`ifdef DMEM_CONSOLE_EN
        // Console stream.
        console_ready = 1'b0;
        wr(BASE + 32'h10, 64'h48, 8'h01);
        wr(BASE + 32'h10, 64'h69, 8'h01);
        check("con_valid", {63'd0, console_valid}, 64'd1);
        check("con_head_H", {56'd0, console_data}, 64'h48);
        rd(BASE + 32'h18, v);
        check("con_status_2", v, 64'h20);
        rd(BASE + 32'h10, v);
        check("con_read_zero", v, 64'd0);
        @(negedge clk);
        console_ready = 1'b1;
        @(posedge clk);
        #1;
        check("con_head_i", {56'd0, console_data}, 64'h69);
        check("con_valid_i", {63'd0, console_valid}, 64'd1);
        @(posedge clk);
        #1;
        check("con_empty", {63'd0, console_valid}, 64'd0);
        console_ready = 1'b0;

        // Overflow, W1C and push+pop while full.
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            wr(BASE + 32'h10, 64'h61 + 64'(i), 8'h01);
        end
        rd(BASE + 32'h18, v);
        check("ovf_status", v, 64'h43);
        check("ovf_head", {56'd0, console_data}, 64'h61);
        wr(BASE + 32'h18, 64'h1, 8'h01);
        rd(BASE + 32'h18, v);
        check("ovf_w1c", v, 64'h42);
        @(negedge clk);
        addr = BASE + 32'h10; wdata = 64'h66; wmask = 8'h01; wr_en = 1'b1; console_ready = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0; wmask = 8'h00; console_ready = 1'b0;
        rd(BASE + 32'h18, v);
        check("full_push_pop", v, 64'h42);
        check("full_push_pop_head", {56'd0, console_data}, 64'h62);
        @(negedge clk);
        console_ready = 1'b1;
        @(posedge clk); #1; check("drain_c", {56'd0, console_data}, 64'h63);
        @(posedge clk); #1; check("drain_d", {56'd0, console_data}, 64'h64);
        @(posedge clk); #1; check("drain_f", {56'd0, console_data}, 64'h66);
        @(posedge clk); #1; check("drain_empty", {63'd0, console_valid}, 64'd0);

        // Push into an empty FIFO with ready high: push only.
        wr(BASE + 32'h10, 64'h7A, 8'h01);
        check("empty_push_pop_valid", {63'd0, console_valid}, 64'd1);
        check("empty_push_pop_data", {56'd0, console_data}, 64'h7A);
        @(posedge clk);
        #1;
        check("empty_push_pop_gone", {63'd0, console_valid}, 64'd0);
        console_ready = 1'b0;
        rd(BASE + 32'h18, v);
        check("status_final", v, 64'd0);
`else
        // Console disabled: writes ignored, outputs tied off.
        wr(BASE + 32'h10, 64'h48, 8'h01);
        check("nocon_valid", {63'd0, console_valid}, 64'd0);
        check("nocon_data", {56'd0, console_data}, 64'd0);
        wr(BASE + 32'h18, 64'hFF, 8'hFF);
        rd(BASE + 32'h18, v);
        check("nocon_status", v, 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-side memory responder for the pipelined RISC-V core: the target end of the processor's doubleword data port (`addr`/`wr_en`/`wdata`/`wmask`/`rdata`). It replaces the bare data-memory model with byte-masked doubleword RAM plus a small MMIO page holding a free-running cycle counter, a `tohost` halt register and a buffered console output. It sits beside the program memory in the top-level system, directly on the processor's data port.

## Interface
Parameters:
- `DEPTH`, 512: RAM doublewords.
- `ADDR_WIDE`, 29: doubleword-index width, taken from `addr[31:3]`.
- `MMIO_BASE`, 32'hFFFF_0000: byte base of the 32-byte MMIO page, 32-byte aligned.
- `FIFO_DEPTH`, 4: console FIFO entries; power of two, 2 to 16.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `addr`  in  32  byte address from the processor.
- `wr_en`  in  1  write strobe.
- `wdata`  in  64  write data.
- `wmask`  in  8  byte enables; bit i enables `wdata[8i+7:8i]`.
- `rdata`  out  64  read data for `addr`.
- `halt`  out  1  high while `tohost` is non-zero.
- `halt_code`  out  32  `tohost[31:0]`.
- `console_valid`  out  1  console FIFO is non-empty.
- `console_data`  out  8  FIFO head byte.
- `console_ready`  in  1  sink accepts the head byte.

## Operation
- Decode:
  - MMIO when `addr[31:5] == MMIO_BASE[31:5]`; offset is `addr[4:3]`.
  - Otherwise RAM, index `addr[31:3]`.
  - RAM index >= DEPTH: reads return 0, writes are ignored.
- RAM: `rdata` is combinational from the array. A write updates only the enabled bytes. RAM contents are not reset.
- MMIO offset 0x00, CYCLE (RO): 64-bit counter.
  - Reset 0; increments every cycle; wraps at 2^64.
  - A read returns the value registered before the current edge.
  - Writes are ignored.
- MMIO offset 0x08, TOHOST (RW): 64-bit register, reset 0, byte-masked write.
  - `halt = |tohost` and is registered.
  - `halt` is sticky until reset or until a write returns the register to 0.
- MMIO offset 0x10, CONSOLE (WO): a write with `wmask[0]=1` pushes `wdata[7:0]`. Reads return 0.
- MMIO offset 0x18, STATUS:
  - Read format: bit0 overflow (sticky), bit1 full, bits[8:4] count, other bits 0.
  - A write with `wmask[0]=1` and `wdata[0]=1` clears overflow (W1C).
- Console FIFO:
  - Push: rising edge with a CONSOLE write as defined above.
  - Pop: rising edge with `console_valid && console_ready`.
  - Push when full with no pop: byte dropped, overflow set.
  - Push and pop together when full: both happen, count unchanged, no overflow.
  - Push and pop together when empty: push only, since `console_valid` is low.
  - Overflow set and W1C in the same cycle: set wins.
  - `console_data` is the head entry; it is undefined while `console_valid` is 0.
- `wr_en=1` with `wmask=0` has no effect anywhere.

## Timing
- Read latency is 0 cycles: `rdata` follows `addr` combinationally.
- A read of an address written in the same cycle returns the old data. The new data is visible after the edge.
- Write-to-`halt` latency is 1 edge.
- Push-to-`console_valid` latency is 1 edge. A pop removes the head at the edge, and the next byte is presented immediately after it.
- Reset values: `halt=0`, `halt_code=0`, `console_valid=0`, CYCLE=0, TOHOST=0, FIFO empty, overflow=0.
- `rdata` is combinational and is not reset.
- Reset asserted mid-operation clears all of the above immediately. RAM is untouched.

## Configuration
- `DMEM_CONSOLE_EN` defined: console FIFO, CONSOLE register and STATUS register are built as specified.
- `DMEM_CONSOLE_EN` undefined:
  - No FIFO is instantiated.
  - CONSOLE and STATUS writes are ignored; STATUS reads return 0.
  - `console_valid=0` and `console_data=0` constantly; `console_ready` is unused.
  - RAM, CYCLE and TOHOST behaviour is unchanged.

## Test plan
- RAM masking: write 64'h1122334455667788 to 0x40 with `wmask`=8'hFF, then 64'hAAAA with `wmask`=8'h03 -> read 0x40 returns 64'h112233445566AAAA. A read at index DEPTH returns 0.
- Cycle counter: release reset and read MMIO_BASE+0x00 on the 10th edge after release -> 10. Two consecutive reads differ by 1.
- Halt: write 64'h1 with `wmask`=8'h0F to MMIO_BASE+0x08 -> `halt=1` and `halt_code=1` after 1 edge. Writing 0 drops `halt`. Asserting `nrst` while halted clears `halt` without waiting for a clock.
- Console stream: with `console_ready=0`, push 'H','i' -> `console_valid=1`, `console_data`=8'h48, STATUS count=2. Raise `console_ready` for 2 cycles -> 'H' then 'i' out, then `console_valid=0`.
- Overflow: `console_ready=0`, push FIFO_DEPTH+1 bytes -> STATUS=32'h43 for FIFO_DEPTH=4 (overflow, full, count 4), last byte dropped. Push and pop in the same cycle while full -> count stays 4 with no new overflow. Writing 1 to STATUS bit0 clears overflow.
- Macro off: build without `DMEM_CONSOLE_EN`, write to CONSOLE -> `console_valid` stays 0 and STATUS reads 0. The RAM and halt tests still pass.
